// File: rtl/bcd_display_driver.sv
// Binary-to-BCD (double-dabble) converter feeding a 4-digit multiplexed seven-segment display.
// Optional macro LEADING_ZERO_BLANK_EN suppresses leading zeros on the hundreds and tens digits.
`timescale 1ns/1ps

module bcd_display_driver #(
   parameter int SCAN_DIV  = 50_000,
   parameter int BLANK_CYC = 500
) (
   input  logic        sys_clk,
   input  logic        rst_n,
   input  logic [7:0]  value,
   output logic [11:0] bcd,
   output logic        bcd_valid,
   output logic        busy,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp
);

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      COMMIT = 2'd2
   } state_t;

   state_t      state, state_nx;
   logic [7:0]  last_val, last_val_nx;
   logic [7:0]  shreg, shreg_nx;
   logic [11:0] scratch, scratch_nx;
   logic [11:0] adj;
   logic [11:0] bcd_nx;
   logic [3:0]  iter, iter_nx;

   function automatic logic [3:0] add3(input logic [3:0] d);
      return (d >= 4'd5) ? d + 4'd3 : d;
   endfunction

   // ---------------- conversion FSM ----------------
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         last_val <= '0;
         shreg    <= '0;
         scratch  <= '0;
         iter     <= '0;
         bcd      <= '0;
      end else begin
         state    <= state_nx;
         last_val <= last_val_nx;
         shreg    <= shreg_nx;
         scratch  <= scratch_nx;
         iter     <= iter_nx;
         bcd      <= bcd_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      last_val_nx = last_val;
      shreg_nx    = shreg;
      scratch_nx  = scratch;
      iter_nx     = iter;
      bcd_nx      = bcd;
      adj         = '0;
      case (state)
         IDLE: begin
            if (value != last_val) begin
               shreg_nx    = value;
               last_val_nx = value;
               scratch_nx  = '0;
               iter_nx     = 4'd8;
               state_nx    = SHIFT;
            end
         end
         SHIFT: begin
            adj        = {add3(scratch[11:8]), add3(scratch[7:4]), add3(scratch[3:0])};
            scratch_nx = (adj << 1) | {11'd0, shreg[7]};
            shreg_nx   = {shreg[6:0], 1'b0};
            iter_nx    = iter - 4'd1;
            // The result is committed on the last iteration so bcd and bcd_valid appear together.
            if (iter == 4'd1) begin
               bcd_nx   = scratch_nx;
               state_nx = COMMIT;
            end
         end
         COMMIT: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   assign busy      = (state == SHIFT);
   assign bcd_valid = (state == COMMIT);

   // ---------------- display scan ----------------
   logic [CW-1:0] scan_cnt;
   logic [1:0]    digit_idx;
   logic [3:0]    digit;
   logic          blank;
   logic [3:0]    an_nx;
   logic [6:0]    seg_nx;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    return 7'b1000000;
         4'd1:    return 7'b1111001;
         4'd2:    return 7'b0100100;
         4'd3:    return 7'b0110000;
         4'd4:    return 7'b0011001;
         4'd5:    return 7'b0010010;
         4'd6:    return 7'b0000010;
         4'd7:    return 7'b1111000;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_cnt  <= '0;
         digit_idx <= '0;
      end else if (scan_cnt == CW'(SCAN_DIV - 1)) begin
         scan_cnt  <= '0;
         digit_idx <= digit_idx + 2'd1;
      end else begin
         scan_cnt  <= scan_cnt + CW'(1);
      end
   end

   always_comb begin
      digit = bcd[3:0];
      blank = 1'b0;
      case (digit_idx)
         2'd0: digit = bcd[3:0];
         2'd1: begin
            digit = bcd[7:4];
`ifdef LEADING_ZERO_BLANK_EN
            blank = (bcd[11:4] == 8'd0);
`endif
         end
         2'd2: begin
            digit = bcd[11:8];
`ifdef LEADING_ZERO_BLANK_EN
            blank = (bcd[11:8] == 4'd0);
`endif
         end
         default: blank = 1'b1;
      endcase
   end

   // an and seg are both registered from the same counter state so they switch together.
   always_comb begin
      seg_nx = blank ? 7'b1111111 : seg7(digit);
      an_nx  = (scan_cnt < CW'(BLANK_CYC)) ? 4'b1111 : ~(4'b0001 << digit_idx);
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         an  <= 4'b1111;
         seg <= 7'b1111111;
      end else begin
         an  <= an_nx;
         seg <= seg_nx;
      end
   end

   assign dp = 1'b1;

endmodule

// File: tb/tb_bcd_display_driver.sv
// Self-checking bench for bcd_display_driver: directed latency/abort sequences, a vector table
// and randomized values checked against an arithmetic decimal/segment reference model.
`timescale 1ns/1ps

module tb_bcd_display_driver;

   localparam int SD = 8;
   localparam int BC = 2;
`ifdef LEADING_ZERO_BLANK_EN
   localparam logic [6:0] LZ = 7'h7F;
`else
   localparam logic [6:0] LZ = 7'h40;
`endif

   logic        sys_clk;
   logic        rst_n;
   logic [7:0]  value;
   logic [11:0] bcd;
   logic        bcd_valid;
   logic        busy;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;

   int n_checks = 0;
   int n_fail   = 0;
   int edges;
   logic [11:0] exp_q[$];

   bcd_display_driver #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
      .sys_clk   (sys_clk),
      .rst_n     (rst_n),
      .value     (value),
      .bcd       (bcd),
      .bcd_valid (bcd_valid),
      .busy      (busy),
      .an        (an),
      .seg       (seg),
      .dp        (dp)
   );

   // ---------------- clock / reset ----------------
   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   always @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) edges <= 0;
      else        edges <= edges + 1;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      n_fail = n_fail + 1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks = n_checks + 1;
      if (act !== exp_v) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp_v, $time);
      end
   endtask

   // Scoreboard: every bcd_valid pulse must match the oldest expected conversion.
   always @(negedge sys_clk) begin
      if (rst_n === 1'b1 && bcd_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_pulse", {20'd0, bcd}, 32'hFFFF_FFFF);
         end else begin
            check("pulse_bcd", {20'd0, bcd}, {20'd0, exp_q.pop_front()});
         end
      end
   end

   // ---------------- reference model ----------------
   function automatic logic [6:0] seg_code(input int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic logic [11:0] model_bcd(input int v);
      return 12'((v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10));
   endfunction

   function automatic logic [6:0] model_seg(input int v, input int pos);
      int h, t, u;
      h = v / 100;
      t = (v / 10) % 10;
      u = v % 10;
      case (pos)
         0: return seg_code(u);
         1: begin
`ifdef LEADING_ZERO_BLANK_EN
            if (h == 0 && t == 0) return 7'h7F;
`endif
            return seg_code(t);
         end
         2: begin
`ifdef LEADING_ZERO_BLANK_EN
            if (h == 0) return 7'h7F;
`endif
            return seg_code(h);
         end
         default: return 7'h7F;
      endcase
   endfunction

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge sys_clk);
         @(negedge sys_clk);
      end
   endtask

   // Watches the scan for ncyc cycles; the expected slot comes from the edge count since reset.
   task automatic check_scan(input logic [6:0] su, input logic [6:0] st, input logic [6:0] sh,
                             input int ncyc);
      int c, idx;
      logic [3:0] ea;
      logic [6:0] es;
      for (int i = 0; i < ncyc; i++) begin
         tick(1);
         c   = (edges - 1) % SD;
         idx = ((edges - 1) / SD) % 4;
         ea  = (c < BC) ? 4'hF : ~(4'(1) << idx);
         check("an", {28'd0, an}, {28'd0, ea});
         check("dp", {31'd0, dp}, 32'd1);
         if (ea != 4'hF) begin
            es = (idx == 0) ? su : (idx == 1) ? st : (idx == 2) ? sh : 7'h7F;
            check("seg", {25'd0, seg}, {25'd0, es});
         end
      end
   endtask

   typedef struct {
      logic [7:0]  v;
      logic [11:0] exp_bcd;
      logic [6:0]  su;
      logic [6:0]  st;
      logic [6:0]  sh;
   } vec_t;

   vec_t tbl[8];

   initial begin
      int prev;
      int v;

      tbl[0] = '{8'd255, 12'h255, 7'h12, 7'h12, 7'h24};
      tbl[1] = '{8'd0,   12'h000, 7'h40, LZ,    LZ};
      tbl[2] = '{8'd7,   12'h007, 7'h78, LZ,    LZ};
      tbl[3] = '{8'd125, 12'h125, 7'h12, 7'h24, 7'h79};
      tbl[4] = '{8'd10,  12'h010, 7'h40, 7'h79, LZ};
      tbl[5] = '{8'd99,  12'h099, 7'h10, 7'h10, LZ};
      tbl[6] = '{8'd200, 12'h200, 7'h40, 7'h40, 7'h24};
      tbl[7] = '{8'd9,   12'h009, 7'h10, LZ,    LZ};

      // Reset state
      rst_n = 1'b0;
      value = 8'd0;
      tick(3);
      check("rst_an", {28'd0, an}, 32'hF);
      check("rst_seg", {25'd0, seg}, 32'h7F);
      check("rst_dp", {31'd0, dp}, 32'd1);
      check("rst_bcd", {20'd0, bcd}, 32'h0);
      check("rst_valid", {31'd0, bcd_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      rst_n = 1'b1;
      tick(20);
      check("idle_bcd", {20'd0, bcd}, 32'h0);
      check("idle_busy", {31'd0, busy}, 32'd0);

      // Latency: 255 sampled at N -> busy from N+1, pulse and result at N+9
      value = 8'd255;
      exp_q.push_back(12'h255);
      for (int k = 1; k <= 10; k++) begin
         tick(1);
         check("lat_busy", {31'd0, busy}, {31'd0, (k >= 1 && k <= 8)});
         check("lat_valid", {31'd0, bcd_valid}, {31'd0, (k == 9)});
         if (k == 8) check("lat_bcd_old", {20'd0, bcd}, 32'h0);
         if (k == 9) check("lat_bcd", {20'd0, bcd}, 32'h255);
      end

      // Value change mid-conversion is picked up by the following conversion
      value = 8'd100;
      exp_q.push_back(12'h100);
      exp_q.push_back(12'h101);
      for (int k = 1; k <= 20; k++) begin
         tick(1);
         if (k == 3) value = 8'd101;
         check("mid_valid", {31'd0, bcd_valid}, {31'd0, (k == 9 || k == 19)});
         if (k == 9)  check("mid_bcd1", {20'd0, bcd}, 32'h100);
         if (k == 19) check("mid_bcd2", {20'd0, bcd}, 32'h101);
      end

      // Reset during a conversion aborts it; the same value converts after release
      value = 8'd200;
      tick(4);
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      check("abort_an", {28'd0, an}, 32'hF);
      check("abort_seg", {25'd0, seg}, 32'h7F);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_bcd", {20'd0, bcd}, 32'h0);
      check("abort_valid", {31'd0, bcd_valid}, 32'd0);
      tick(2);
      rst_n = 1'b1;
      exp_q.push_back(12'h200);
      tick(12);
      check("restart_bcd", {20'd0, bcd}, 32'h200);
      prev = 200;

      // Vector table: conversion result plus a full scan of the display
      for (int i = 0; i < 8; i++) begin
         if (int'(tbl[i].v) != prev) exp_q.push_back(tbl[i].exp_bcd);
         value = tbl[i].v;
         tick(12);
         check("tbl_bcd", {20'd0, bcd}, {20'd0, tbl[i].exp_bcd});
         check_scan(tbl[i].su, tbl[i].st, tbl[i].sh, 4 * SD);
         prev = int'(tbl[i].v);
      end

      // Randomized values against the arithmetic model
      for (int i = 0; i < 30; i++) begin
         v = int'($urandom_range(0, 255));
         if (v != prev) exp_q.push_back(model_bcd(v));
         value = 8'(v);
         tick(12);
         check("rnd_bcd", {20'd0, bcd}, {20'd0, model_bcd(v)});
         check_scan(model_seg(v, 0), model_seg(v, 1), model_seg(v, 2), 4 * SD);
         prev = v;
      end

      tick(2);
      check("pending_pulses", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
